// File: rtl/encoder16_4_irq.sv
`default_nettype none
// ============================================================================
//  Module      : encoder16_4_irq
//  Description : Sequential 16-to-4 priority encoder. Request lines are
//                captured into a sticky pending register; the highest set
//                pending bit is presented as a binary code with a valid/ack
//                handshake and cleared once accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module encoder16_4_irq #(
    parameter int EDGE_MODE = 1,
    parameter int N         = 16,
    parameter int W         = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] D,
    input  logic         ack,
    output logic [W-1:0] Y,
    output logic         valid,
    output logic [N-1:0] pend,
    output logic         ovf
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_GAP     = 2'd2
    } state_t;

    localparam logic [N-1:0] c_one = {{(N-1){1'b0}}, 1'b1};

    state_t         r_state;
    state_t         w_state_next;
    logic [N-1:0]   r_prev;
    logic [N-1:0]   r_pend;
    logic [W-1:0]   r_y;
    logic [W-1:0]   w_y_next;
    logic           r_valid;
    logic           w_valid_next;
    logic           r_ovf;

    logic [N-1:0]   w_cap;
    logic [N-1:0]   w_clr;
    logic [N-1:0]   w_pend_next;
    logic           w_ovf_next;
    logic           w_ack_accept;
    logic [W-1:0]   w_top_idx;

    // Request capture: rising edges against last cycle's D, or raw level.
    always_comb begin
        w_cap = '0;
        if (EDGE_MODE != 0) begin
            w_cap = D & ~r_prev;
        end else begin
            w_cap = D;
        end
    end

    // Clear mask for the presented bit, only when an ack is accepted in PRESENT.
    // Set takes precedence over clear so a request landing on the ack cycle survives.
    always_comb begin
        w_ack_accept = (r_state == ST_PRESENT) && ack;
        w_clr        = w_ack_accept ? (c_one << r_y) : '0;
        w_pend_next  = (r_pend & ~w_clr) | w_cap;
        w_ovf_next   = |(w_cap & r_pend & ~w_clr);
    end

    // Highest-index set bit of the pending register (bit N-1 wins).
    always_comb begin
        w_top_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (r_pend[i]) begin
                w_top_idx = W'(i);
            end
        end
    end

    // Edge history, pending register and overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_pend <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_prev <= D;
            r_pend <= w_pend_next;
            r_ovf  <= w_ovf_next;
        end
    end

    // Handshake FSM state and presented code registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_y     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_y     <= w_y_next;
            r_valid <= w_valid_next;
        end
    end

    // Next-state logic: present in IDLE, hold until ack, one forced gap cycle.
    always_comb begin
        w_state_next = r_state;
        w_y_next     = r_y;
        w_valid_next = r_valid;
        case (r_state)
            ST_IDLE: begin
                w_valid_next = 1'b0;
                if (en && (r_pend != '0)) begin
                    w_y_next     = w_top_idx;
                    w_valid_next = 1'b1;
                    w_state_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (ack) begin
                    w_valid_next = 1'b0;
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                w_valid_next = 1'b0;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_valid_next = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign Y     = r_y;
    assign valid = r_valid;
    assign pend  = r_pend;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_encoder16_4_irq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encoder16_4_irq
//  Description : Directed self-checking bench for encoder16_4_irq, with an
//                edge-mode instance and a level-mode instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder16_4_irq;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] d;
    logic        ack;
    logic [3:0]  y;
    logic        valid;
    logic [15:0] pend;
    logic        ovf;

    logic        l_en;
    logic [15:0] l_d;
    logic        l_ack;
    logic [3:0]  l_y;
    logic        l_valid;
    logic [15:0] l_pend;
    logic        l_ovf;

    int n_cmp;
    int n_bad;

    encoder16_4_irq #(.EDGE_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .D(d), .ack(ack),
        .Y(y), .valid(valid), .pend(pend), .ovf(ovf)
    );

    encoder16_4_irq #(.EDGE_MODE(0)) dut_lvl (
        .clk(clk), .rst_n(rst_n), .en(l_en), .D(l_d), .ack(l_ack),
        .Y(l_y), .valid(l_valid), .pend(l_pend), .ovf(l_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs then reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge-mode DUT full observation.
    task automatic chk_all(input string tag, input logic v, input logic [3:0] yy,
                           input logic [15:0] p, input logic o);
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        if (v) chk({tag, ".Y"}, 32'(y), 32'(yy));
        chk({tag, ".pend"}, 32'(pend), 32'(p));
        chk({tag, ".ovf"}, 32'(ovf), 32'(o));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        en = 1'b0; d = '0; ack = 1'b0;
        l_en = 1'b1; l_d = '0; l_ack = 1'b0;

        // Reset state
        #12;
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.Y", 32'(y), 32'd0);
        chk("rst.pend", 32'(pend), 32'd0);
        chk("rst.ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;

        // Idle with no requests
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle.valid", 32'(valid), 32'd0);
            chk("idle.Y", 32'(y), 32'd0);
            chk("idle.pend", 32'(pend), 32'd0);
        end

        // Two requests presented in priority order
        en = 1'b1;
        d = 16'h0024; tick(); d = '0;
        chk_all("t2.cap", 1'b0, 4'd0, 16'h0024, 1'b0);
        tick(); chk_all("t2.pres5", 1'b1, 4'd5, 16'h0024, 1'b0);
        tick(); chk_all("t2.hold5", 1'b1, 4'd5, 16'h0024, 1'b0);
        ack = 1'b1; tick(); ack = 1'b0;
        chk_all("t2.ack5", 1'b0, 4'd0, 16'h0004, 1'b0);
        tick(); chk_all("t2.gap", 1'b0, 4'd0, 16'h0004, 1'b0);
        tick(); chk_all("t2.pres2", 1'b1, 4'd2, 16'h0004, 1'b0);
        ack = 1'b1; tick(); ack = 1'b0;
        chk_all("t2.ack2", 1'b0, 4'd0, 16'h0000, 1'b0);
        tick(); tick();
        chk_all("t2.idle", 1'b0, 4'd0, 16'h0000, 1'b0);

        // en gates presentation but not capture
        en = 1'b0;
        d = 16'h8001; tick(); d = '0;
        chk_all("t3.cap", 1'b0, 4'd0, 16'h8001, 1'b0);
        tick(); tick();
        chk_all("t3.gated", 1'b0, 4'd0, 16'h8001, 1'b0);
        en = 1'b1; tick();
        chk_all("t3.pres15", 1'b1, 4'd15, 16'h8001, 1'b0);
        ack = 1'b1; tick(); ack = 1'b0;
        chk_all("t3.ack15", 1'b0, 4'd0, 16'h0001, 1'b0);
        tick(); tick();
        chk_all("t3.pres0", 1'b1, 4'd0, 16'h0001, 1'b0);
        ack = 1'b1; tick(); ack = 1'b0;
        chk_all("t3.ack0", 1'b0, 4'd0, 16'h0000, 1'b0);
        tick(); tick();

        // Overflow and priority hold during PRESENT
        d = 16'h0008; tick(); d = '0;
        tick(); chk_all("t4.pres3", 1'b1, 4'd3, 16'h0008, 1'b0);
        d = 16'h0208; tick(); d = '0;
        chk_all("t4.ovf", 1'b1, 4'd3, 16'h0208, 1'b1);
        tick(); chk_all("t4.ovfpulse", 1'b1, 4'd3, 16'h0208, 1'b0);
        ack = 1'b1; tick(); ack = 1'b0;
        chk_all("t4.ack3", 1'b0, 4'd0, 16'h0200, 1'b0);
        tick(); tick();
        chk_all("t4.pres9", 1'b1, 4'd9, 16'h0200, 1'b0);
        d = 16'h0008; tick(); d = '0;
        chk_all("t4.re3", 1'b1, 4'd9, 16'h0208, 1'b0);
        ack = 1'b1; tick(); ack = 1'b0;
        chk_all("t4.ack9", 1'b0, 4'd0, 16'h0008, 1'b0);
        tick(); tick();
        chk_all("t4.pres3b", 1'b1, 4'd3, 16'h0008, 1'b0);
        ack = 1'b1; tick(); ack = 1'b0;
        tick(); tick();
        chk_all("t4.idle", 1'b0, 4'd0, 16'h0000, 1'b0);

        // Set wins over clear on the ack cycle
        d = 16'h0080; tick(); d = '0;
        tick(); chk_all("t5.pres7", 1'b1, 4'd7, 16'h0080, 1'b0);
        ack = 1'b1; d = 16'h0080; tick(); ack = 1'b0; d = '0;
        chk_all("t5.setwins", 1'b0, 4'd0, 16'h0080, 1'b0);
        tick(); chk_all("t5.gap", 1'b0, 4'd0, 16'h0080, 1'b0);
        tick(); chk_all("t5.re7", 1'b1, 4'd7, 16'h0080, 1'b0);
        ack = 1'b1; tick(); ack = 1'b0;
        tick(); tick();
        chk_all("t5.idle", 1'b0, 4'd0, 16'h0000, 1'b0);

        // Ack outside PRESENT is ignored
        ack = 1'b1; tick(); ack = 1'b0;
        chk_all("t5b.strayack", 1'b0, 4'd0, 16'h0000, 1'b0);

        // Asynchronous reset mid-presentation
        d = 16'h1000; tick(); d = '0;
        tick(); chk_all("t6.pres12", 1'b1, 4'd12, 16'h1000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6.async.valid", 32'(valid), 32'd0);
        chk("t6.async.Y", 32'(y), 32'd0);
        chk("t6.async.pend", 32'(pend), 32'd0);
        chk("t6.async.ovf", 32'(ovf), 32'd0);
        d = 16'h0010;
        #1 rst_n = 1'b1;
        tick(); chk_all("t6.cap4", 1'b0, 4'd0, 16'h0010, 1'b0);
        tick(); chk_all("t6.pres4", 1'b1, 4'd4, 16'h0010, 1'b0);
        ack = 1'b1; tick(); ack = 1'b0;
        chk_all("t6.ack4", 1'b0, 4'd0, 16'h0000, 1'b0);
        tick(); tick();
        chk_all("t6.noretrig", 1'b0, 4'd0, 16'h0000, 1'b0);
        d = '0;

        // Level mode: held request re-presented, ovf on held pending bit
        l_d = 16'h0080; tick();
        chk("lv.cap.pend", 32'(l_pend), 32'h0080);
        chk("lv.cap.ovf", 32'(l_ovf), 32'd0);
        tick();
        chk("lv.pres.valid", 32'(l_valid), 32'd1);
        chk("lv.pres.Y", 32'(l_y), 32'd7);
        chk("lv.pres.ovf", 32'(l_ovf), 32'd1);
        l_ack = 1'b1; tick(); l_ack = 1'b0;
        chk("lv.ack.valid", 32'(l_valid), 32'd0);
        chk("lv.ack.pend", 32'(l_pend), 32'h0080);
        chk("lv.ack.ovf", 32'(l_ovf), 32'd0);
        tick();
        chk("lv.gap.ovf", 32'(l_ovf), 32'd1);
        tick();
        chk("lv.re.valid", 32'(l_valid), 32'd1);
        chk("lv.re.Y", 32'(l_y), 32'd7);
        l_d = '0; l_ack = 1'b1; tick(); l_ack = 1'b0;
        chk("lv.done.pend", 32'(l_pend), 32'h0000);
        chk("lv.done.valid", 32'(l_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
